// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Phase lengths and the bypass test live here so every channel uses the same arithmetic.
package clk_div_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Odd ratios put the extra reference cycle in the low phase.
    function automatic int unsigned low_len(input int unsigned r);
        return (r + 1) >> 1;
    endfunction

    function automatic int unsigned high_len(input int unsigned r);
        return r >> 1;
    endfunction

    function automatic logic is_bypass(input logic en, input int unsigned r);
        return (!en) || (r < 2);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Per-channel enable/ratio inputs and divided-clock/tick/update outputs of clk_div_multi.
// The slave modport is the divider side, the master modport is the controlling side.
interface clk_div_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 4
);

    logic [NUM_CH-1:0]       i_clk_en;
    logic [NUM_CH*DIV_W-1:0] i_div_ratio;
    logic [NUM_CH-1:0]       o_div_clk;
    logic [NUM_CH-1:0]       o_tick;
    logic [NUM_CH-1:0]       o_ratio_upd;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_tick,
        input  o_ratio_upd
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_tick,
        output o_ratio_upd
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, low/high phase FSM, boundary ratio latch, tick and update pulses.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge flop for true 50% duty on odd ratios.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_ratio_upd
);

    phase_e           phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] r_act_q, r_act_d;
    logic             tick_q, tick_d;
    logic             upd_q, upd_d;

    logic             div_q;
    logic             bypass;
    logic             divOut;
    logic [DIV_W-1:0] lowLast;
    logic [DIV_W-1:0] highLast;

    assign div_q    = (phase_q == PH_HIGH);
    assign bypass   = is_bypass(i_clk_en, 32'(r_act_q));
    assign lowLast  = DIV_W'(low_len(32'(r_act_q)) - 32'd1);
    assign highLast = DIV_W'(high_len(32'(r_act_q)) - 32'd1);

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= PH_LOW;
            cnt_q   <= '0;
            r_act_q <= '0;
            tick_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            r_act_q <= r_act_d;
            tick_q  <= tick_d;
            upd_q   <= upd_d;
        end
    end

    // The ratio is only re-latched at the low-to-high boundary, so a period in flight never shortens.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        r_act_d = r_act_q;
        tick_d  = 1'b0;
        upd_d   = 1'b0;
        if (bypass) begin
            phase_d = PH_LOW;
            cnt_d   = '0;
            r_act_d = i_ratio;
            tick_d  = i_clk_en;
        end else begin
            unique case (phase_q)
                PH_LOW: begin
                    if (cnt_q == lowLast) begin
                        phase_d = PH_HIGH;
                        cnt_d   = '0;
                        r_act_d = i_ratio;
                        tick_d  = 1'b1;
                        upd_d   = (i_ratio != r_act_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (cnt_q == highLast) begin
                        phase_d = PH_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic div_neg_q;

    // Half-cycle delayed copy stretches the short high phase of odd ratios by half a reference period.
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            div_neg_q <= 1'b0;
        end else begin
            div_neg_q <= div_q;
        end
    end

    assign divOut = r_act_q[0] ? (div_q | div_neg_q) : div_q;
`else
    assign divOut = div_q;
`endif

    assign o_div_clk   = bypass ? i_ref_clk : divOut;
    assign o_tick      = tick_q;
    assign o_ratio_upd = upd_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider; one clk_div_ch per channel sharing i_ref_clk.
// Optional macro CLK_DIV_ODD_DUTY50_EN selects true 50% duty for odd ratios in every channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 4
) (
    input  logic            i_ref_clk,
    input  logic            i_rst,
    clk_div_multi_if.slave  bus
);

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        clk_div_ch #(
            .DIV_W (DIV_W)
        ) uCh (
            .i_ref_clk   (i_ref_clk),
            .i_rst       (i_rst),
            .i_clk_en    (bus.i_clk_en[c]),
            .i_ratio     (bus.i_div_ratio[c*DIV_W +: DIV_W]),
            .o_div_clk   (bus.o_div_clk[c]),
            .o_tick      (bus.o_tick[c]),
            .o_ratio_upd (bus.o_ratio_upd[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: table-driven period/duty/tick vectors plus corner sequences.
// Expected odd-ratio duty follows CLK_DIV_ODD_DUTY50_EN when that macro is defined.
`timescale 1ns/100ps
module tb_clk_div_multi;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 4;

    typedef struct {
        logic [1:0] en;
        logic [3:0] r0;
        logic [3:0] r1;
        int         low0;
        int         high0;
        int         low1;
        int         high1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[4];

    always #50 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W)
    ) dut (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [3:0] r0, input logic [3:0] r1);
        bus.i_clk_en    = en;
        bus.i_div_ratio = {r1, r0};
    endtask

    task automatic waitLevel(input int ch, input logic lvl, output realtime t);
        int n = 0;
        while (bus.o_div_clk[ch] !== lvl && n < 4000) begin
            #1;
            n++;
        end
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_ch%0d: level %0d never seen", ch, lvl);
        end
        t = $realtime;
    endtask

    task automatic measure(input int ch, output int lowNs, output int highNs);
        realtime t0, t1, t2;
        @(posedge clk);
        #3.5;
        waitLevel(ch, 1'b0, t0);
        waitLevel(ch, 1'b1, t0);
        waitLevel(ch, 1'b0, t1);
        waitLevel(ch, 1'b1, t2);
        highNs = int'(t1 - t0);
        lowNs  = int'(t2 - t1);
    endtask

    task automatic countTicks(input int ch, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #3.5;
            n += int'(bus.o_tick[ch]);
        end
    endtask

    initial begin
        int      lo, hi, nt;
        realtime tA, tB;

`ifdef CLK_DIV_ODD_DUTY50_EN
        vecs[0] = '{2'b11, 4'd4,  4'd6, 200, 200, 300, 300};
        vecs[1] = '{2'b11, 4'd3,  4'd6, 150, 150, 300, 300};
        vecs[2] = '{2'b11, 4'd2,  4'd5, 100, 100, 250, 250};
        vecs[3] = '{2'b11, 4'd15, 4'd8, 750, 750, 400, 400};
`else
        vecs[0] = '{2'b11, 4'd4,  4'd6, 200, 200, 300, 300};
        vecs[1] = '{2'b11, 4'd3,  4'd6, 200, 100, 300, 300};
        vecs[2] = '{2'b11, 4'd2,  4'd5, 100, 100, 300, 200};
        vecs[3] = '{2'b11, 4'd15, 4'd8, 800, 700, 400, 400};
`endif

        applyStimulus(2'b00, 4'd0, 4'd0);
        rst = 1'b1;

        // Reset state: ticks/updates low, both outputs follow the reference clock.
        @(posedge clk);
        #20;
        checkOutput("rst_divclk0_hi", int'(bus.o_div_clk[0]), 1);
        checkOutput("rst_divclk1_hi", int'(bus.o_div_clk[1]), 1);
        checkOutput("rst_tick", int'(bus.o_tick), 0);
        checkOutput("rst_upd", int'(bus.o_ratio_upd), 0);
        @(negedge clk);
        #20;
        checkOutput("rst_divclk0_lo", int'(bus.o_div_clk[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // Ratio 1: bypass with tick every cycle.
        applyStimulus(2'b01, 4'd1, 4'd0);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #3.5;
            checkOutput($sformatf("byp_tick0_%0d", k), int'(bus.o_tick[0]), 1);
            #20;
            checkOutput($sformatf("byp_clk_hi_%0d", k), int'(bus.o_div_clk[0]), 1);
            #50;
            checkOutput($sformatf("byp_clk_lo_%0d", k), int'(bus.o_div_clk[0]), 0);
        end
        checkOutput("byp_tick1_off", int'(bus.o_tick[1]), 0);

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].en, vecs[v].r0, vecs[v].r1);
            repeat (40) @(posedge clk);
            measure(0, lo, hi);
            checkOutput($sformatf("v%0d_ch0_low", v), lo, vecs[v].low0);
            checkOutput($sformatf("v%0d_ch0_high", v), hi, vecs[v].high0);
            measure(1, lo, hi);
            checkOutput($sformatf("v%0d_ch1_low", v), lo, vecs[v].low1);
            checkOutput($sformatf("v%0d_ch1_high", v), hi, vecs[v].high1);
            countTicks(0, 4 * int'(vecs[v].r0), nt);
            checkOutput($sformatf("v%0d_ch0_ticks", v), nt, 4);
            countTicks(1, 4 * int'(vecs[v].r1), nt);
            checkOutput($sformatf("v%0d_ch1_ticks", v), nt, 4);
        end

        // Ratio 4 -> 7 inside a low phase: the running period still ends at 4.
        applyStimulus(2'b11, 4'd4, 4'd6);
        repeat (30) @(posedge clk);
        @(posedge clk);
        #3.5;
        waitLevel(0, 1'b1, tA);
        waitLevel(0, 1'b0, tA);
        @(posedge clk);
        #3.5;
        applyStimulus(2'b11, 4'd7, 4'd6);
        waitLevel(0, 1'b1, tB);
        checkOutput("chg_last_low", int'(tB - tA), 200);
        checkOutput("chg_upd0_pulse", int'(bus.o_ratio_upd[0]), 1);
        checkOutput("chg_upd1_quiet", int'(bus.o_ratio_upd[1]), 0);
        @(posedge clk);
        #3.5;
        checkOutput("chg_upd0_end", int'(bus.o_ratio_upd[0]), 0);
        measure(0, lo, hi);
`ifdef CLK_DIV_ODD_DUTY50_EN
        checkOutput("chg_new_low", lo, 350);
        checkOutput("chg_new_high", hi, 350);
`else
        checkOutput("chg_new_low", lo, 400);
        checkOutput("chg_new_high", hi, 300);
`endif

        // Enable dropped mid-high with ratio 5, then re-enabled: 3 low, 2 high.
        applyStimulus(2'b11, 4'd5, 4'd6);
        repeat (30) @(posedge clk);
        @(posedge clk);
        #3.5;
        waitLevel(0, 1'b0, tA);
        waitLevel(0, 1'b1, tA);
        @(posedge clk);
        #3;
        applyStimulus(2'b10, 4'd5, 4'd6);
        #10;
        checkOutput("dis_follow_hi", int'(bus.o_div_clk[0]), 1);
        #50;
        checkOutput("dis_follow_lo", int'(bus.o_div_clk[0]), 0);
        @(posedge clk);
        #3;
        applyStimulus(2'b11, 4'd5, 4'd6);
        for (int k = 0; k < 6; k++) begin
            #50;
            checkOutput($sformatf("reen_cyc%0d", k), int'(bus.o_div_clk[0]), (k == 3 || k == 4) ? 1 : 0);
            #50;
        end

        // Asynchronous reset between edges during ratio 8, then ratio 15 after release.
        applyStimulus(2'b11, 4'd8, 4'd6);
        repeat (30) @(posedge clk);
        @(posedge clk);
        #3.5;
        waitLevel(0, 1'b1, tA);
        waitLevel(0, 1'b0, tA);
        #129.5;
        rst = 1'b1;
        #10;
        checkOutput("arst_divclk0_hi", int'(bus.o_div_clk[0]), 1);
        checkOutput("arst_tick", int'(bus.o_tick), 0);
        checkOutput("arst_upd", int'(bus.o_ratio_upd), 0);
        #20;
        checkOutput("arst_divclk0_lo", int'(bus.o_div_clk[0]), 0);
        checkOutput("arst_divclk1_lo", int'(bus.o_div_clk[1]), 0);
        applyStimulus(2'b11, 4'd15, 4'd6);
        @(negedge clk);
        rst = 1'b0;
        measure(0, lo, hi);
`ifdef CLK_DIV_ODD_DUTY50_EN
        checkOutput("r15_low", lo, 750);
        checkOutput("r15_high", hi, 750);
`else
        checkOutput("r15_low", lo, 800);
        checkOutput("r15_high", hi, 700);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
